// File: rtl/tour_cmd_sequencer_if.sv
// rtl/tour_cmd_sequencer_if.sv - host and RemoteComm signal bundle for the command sequencer
interface tour_cmd_sequencer_if;
  logic        wr_cmd;
  logic [15:0] cmd_in;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        full;
  logic        empty;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  cmd_cnt;

  // master: the host plus RemoteComm side; slave: the sequencer itself
  modport master (
    output wr_cmd, cmd_in, start, abort, cmd_snt, resp_rdy, resp,
    input  cmd, snd_cmd, full, empty, busy, done, err, err_code, cmd_cnt
  );

  modport slave (
    input  wr_cmd, cmd_in, start, abort, cmd_snt, resp_rdy, resp,
    output cmd, snd_cmd, full, empty, busy, done, err, err_code, cmd_cnt
  );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - queues commands and drains them one by one through RemoteComm
module tour_cmd_sequencer #(
  parameter int          DEPTH    = 8,
  parameter logic [23:0] RESP_TMO = 24'd10_000_000,
  parameter logic [7:0]  RESP_OK  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tour_cmd_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SNT, WAIT_RESP, FAIL} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   cmd_q;
  logic [23:0]   tmo_cnt;
  logic          done_q, err_q;
  logic [1:0]    err_code_q, fail_code;
  logic [4:0]    cmd_cnt_q;

  logic full_w, empty_w, push, pop, flush, in_wait, tmo_hit, start_ok, resp_good, go_fail;

  assign full_w   = (count == FULL_CNT);
  assign empty_w  = (count == '0);
  assign flush    = (state == FAIL);
  assign pop      = (state == LOAD);
  assign push     = bus.wr_cmd && !full_w && !flush;
  assign in_wait  = (state == WAIT_SNT) || (state == WAIT_RESP);
  assign start_ok = (state == IDLE) && bus.start;
  // Fires on the cycle whose increment would bring the counter to RESP_TMO-1,
  // so FAIL is entered exactly RESP_TMO cycles after SEND.
  assign tmo_hit  = in_wait && ((tmo_cnt + 24'd1) == (RESP_TMO - 24'd1));

  always_comb begin
    state_nxt = state;
    fail_code = 2'b00;
    go_fail   = 1'b0;
    resp_good = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !empty_w) state_nxt = LOAD;
      end
      LOAD:     state_nxt = SEND;
      SEND:     state_nxt = WAIT_SNT;
      WAIT_SNT: begin
        if (tmo_hit) begin
          go_fail   = 1'b1;
          fail_code = 2'b10;
        end else if (bus.cmd_snt) begin
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (tmo_hit) begin
          go_fail   = 1'b1;
          fail_code = 2'b10;
        end else if (bus.resp_rdy) begin
          if (bus.resp == RESP_OK) begin
            resp_good = 1'b1;
            state_nxt = empty_w ? IDLE : LOAD;
          end else begin
            go_fail   = 1'b1;
            fail_code = 2'b01;
          end
        end
      end
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && (state != IDLE)) begin
      go_fail   = 1'b1;
      fail_code = 2'b11;
      resp_good = 1'b0;
    end
    if (go_fail) state_nxt = FAIL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      tmo_cnt    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      cmd_cnt_q  <= '0;
    end else begin
      if (pop) cmd_q <= mem[rd_ptr];

      if (state_nxt == SEND)  tmo_cnt <= '0;
      else if (in_wait)       tmo_cnt <= tmo_cnt + 24'd1;

      done_q <= empty_w && (start_ok || resp_good);

      if (start_ok) begin
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
      end else if (go_fail) begin
        err_q      <= 1'b1;
        err_code_q <= fail_code;
      end

      if (start_ok)                            cmd_cnt_q <= '0;
      else if (resp_good && cmd_cnt_q != 5'd31) cmd_cnt_q <= cmd_cnt_q + 5'd1;
    end
  end

  assign bus.cmd      = cmd_q;
  assign bus.snd_cmd  = (state == SEND);
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.cmd_cnt  = cmd_cnt_q;
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb/tb_tour_cmd_sequencer.sv - randomized self-checking bench for tour_cmd_sequencer
module tb_tour_cmd_sequencer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  tour_cmd_sequencer_if bus();

  tour_cmd_sequencer #(.DEPTH(DEPTH), .RESP_TMO(24'd100), .RESP_OK(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] model_q[$];
  logic [15:0] got_cmds[$];
  int lat_bad, stab_bad, hung, done_total, n_checks, n_fail;

  always @(negedge clk) if (bus.done === 1'b1) done_total++;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [15:0] v);
    @(posedge clk); #1;
    bus.wr_cmd = 1'b1;
    bus.cmd_in = v;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    @(posedge clk); #1;
    bus.wr_cmd = 1'b0;
  endtask

  // Pulses start and plays RemoteComm with random delays until the sequencer goes idle.
  task automatic drive_seq(input int bad_idx, input logic [7:0] bad_val, input int max_cyc);
    int ph, wt, idx, cyc, since;
    logic [15:0] cur;
    ph = 0; wt = 0; idx = 0; cyc = 0; cur = '0;
    got_cmds.delete(); lat_bad = 0; stab_bad = 0; hung = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    since = 0;
    forever begin
      @(negedge clk);
      since++; cyc++;
      if (!bus.busy) break;
      if (cyc > max_cyc) begin hung = 1; break; end
      if (ph == 0 && bus.snd_cmd) begin
        cur = bus.cmd;
        got_cmds.push_back(bus.cmd);
        if (since != 2) lat_bad++;
        ph = 1;
        wt = $urandom_range(0, 3);
      end else if (ph != 0 && bus.cmd !== cur) begin
        stab_bad++;
      end
      @(posedge clk); #1;
      bus.cmd_snt = 1'b0;
      bus.resp_rdy = 1'b0;
      if (ph == 1) begin
        if (wt == 0) begin bus.cmd_snt = 1'b1; ph = 2; wt = $urandom_range(0, 3); end
        else wt--;
      end else if (ph == 2) begin
        if (wt == 0) begin
          bus.resp_rdy = 1'b1;
          bus.resp = (idx == bad_idx) ? bad_val : 8'hA5;
          idx++; ph = 0; since = -1;
        end else wt--;
      end
    end
    @(posedge clk); #1;
    bus.cmd_snt = 1'b0;
    bus.resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_cmd = 0; bus.cmd_in = '0; bus.start = 0; bus.abort = 0;
    bus.cmd_snt = 0; bus.resp_rdy = 0; bus.resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %0h want 0", bus.cmd); end
    n_checks++; if (bus.snd_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_snd: got %0h want 0", bus.snd_cmd); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", bus.done); end
    n_checks++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %0h/%0h want 0/0", bus.err, bus.err_code); end
    n_checks++; if (bus.cmd_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.cmd_cnt); end
    n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo: empty %0h full %0h want 1 0", bus.empty, bus.full); end
  endtask

  task automatic test_basic();
    int d0;
    model_q.delete();
    push_cmd(16'h0000);
    push_cmd(16'h3BF2);
    d0 = done_total;
    drive_seq(-1, 8'h00, 200);
    n_checks++; if (got_cmds.size() != 2) begin n_fail++; $display("FAIL basic_nsnd: got %0d want 2", got_cmds.size()); end
    if (got_cmds.size() == 2) begin
      n_checks++; if (got_cmds[0] !== 16'h0000) begin n_fail++; $display("FAIL basic_cmd0: got %0h want 0", got_cmds[0]); end
      n_checks++; if (got_cmds[1] !== 16'h3BF2) begin n_fail++; $display("FAIL basic_cmd1: got %0h want 3bf2", got_cmds[1]); end
    end
    n_checks++; if (bus.cmd_cnt !== 5'd2) begin n_fail++; $display("FAIL basic_cnt: got %0d want 2", bus.cmd_cnt); end
    n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_total - d0); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %0h want 0", bus.err); end
    n_checks++; if (lat_bad != 0 || hung != 0) begin n_fail++; $display("FAIL basic_latency: got %0d late, hung %0d want 0 0", lat_bad, hung); end
    model_q.delete();
  endtask

  task automatic test_random_ok();
    int n, d0;
    for (int it = 0; it < 6; it++) begin
      model_q.delete();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) push_cmd(16'($urandom));
      d0 = done_total;
      drive_seq(-1, 8'h00, 400);
      n_checks++; if (got_cmds.size() != model_q.size()) begin n_fail++; $display("FAIL rand_nsnd: got %0d want %0d", got_cmds.size(), model_q.size()); end
      for (int j = 0; j < got_cmds.size() && j < model_q.size(); j++) begin
        n_checks++; if (got_cmds[j] !== model_q[j]) begin n_fail++; $display("FAIL rand_cmd[%0d]: got %0h want %0h", j, got_cmds[j], model_q[j]); end
      end
      n_checks++; if (bus.cmd_cnt !== 5'(n)) begin n_fail++; $display("FAIL rand_cnt: got %0d want %0d", bus.cmd_cnt, n); end
      n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL rand_done: got %0d pulses want 1", done_total - d0); end
      n_checks++; if (bus.err !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rand_state: err %0h empty %0h want 0 1", bus.err, bus.empty); end
      n_checks++; if (lat_bad != 0 || stab_bad != 0 || hung != 0) begin n_fail++; $display("FAIL rand_timing: late %0d unstable %0d hung %0d want 0 0 0", lat_bad, stab_bad, hung); end
    end
    model_q.delete();
  endtask

  task automatic test_bad_resp();
    int n, bad, d0;
    logic [7:0] bv;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        n = 1; bad = 0; bv = 8'h5A;
      end else begin
        n = $urandom_range(1, DEPTH);
        bad = $urandom_range(0, n - 1);
        bv = 8'($urandom);
        if (bv == 8'hA5) bv = 8'h5A;
      end
      model_q.delete();
      for (int j = 0; j < n; j++) push_cmd(16'($urandom));
      d0 = done_total;
      drive_seq(bad, bv, 400);
      n_checks++; if (got_cmds.size() != bad + 1) begin n_fail++; $display("FAIL bad_nsnd: got %0d want %0d", got_cmds.size(), bad + 1); end
      for (int j = 0; j < got_cmds.size() && j <= bad; j++) begin
        n_checks++; if (got_cmds[j] !== model_q[j]) begin n_fail++; $display("FAIL bad_cmd[%0d]: got %0h want %0h", j, got_cmds[j], model_q[j]); end
      end
      n_checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b01) begin n_fail++; $display("FAIL bad_err: got %0h/%0h want 1/1", bus.err, bus.err_code); end
      n_checks++; if (bus.cmd_cnt !== 5'(bad)) begin n_fail++; $display("FAIL bad_cnt: got %0d want %0d", bus.cmd_cnt, bad); end
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL bad_flush: empty %0h want 1", bus.empty); end
      n_checks++; if (done_total != d0 || hung != 0) begin n_fail++; $display("FAIL bad_done: got %0d pulses hung %0d want 0 0", done_total - d0, hung); end
    end
    model_q.delete();
  endtask

  task automatic test_timeout();
    int k;
    logic hit;
    for (int mode = 0; mode < 4; mode++) begin
      model_q.delete();
      push_cmd(16'h1000 + 16'(mode));
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      hit = 1'b0;
      for (int t = 0; t < 10 && !hit; t++) begin @(negedge clk); hit = bus.snd_cmd; end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL tmo_snd: got %0h want 1", hit); end
      k = 0;
      while (k < 150) begin
        @(posedge clk); #1;
        bus.cmd_snt  = (mode > 0) && (k == 2);
        bus.resp_rdy = (mode == 2 && k == 98) || (mode == 3 && k == 97);
        bus.resp     = 8'hA5;
        @(negedge clk);
        k++;
        if (bus.err || !bus.busy) break;
      end
      @(posedge clk); #1;
      bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0;
      if (mode < 3) begin
        n_checks++; if (k != 100) begin n_fail++; $display("FAIL tmo_cycles(m%0d): got %0d want 100", mode, k); end
        n_checks++; if (bus.err_code !== 2'b10 || bus.cmd_cnt !== 5'd0) begin n_fail++; $display("FAIL tmo_code(m%0d): got %0h cnt %0d want 2 0", mode, bus.err_code, bus.cmd_cnt); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL tmo_idle(m%0d): busy %0h empty %0h want 0 1", mode, bus.busy, bus.empty); end
      end else begin
        n_checks++; if (k != 99 || bus.err !== 1'b0 || bus.cmd_cnt !== 5'd1) begin n_fail++; $display("FAIL tmo_edge_ok: cyc %0d err %0h cnt %0d want 99 0 1", k, bus.err, bus.cmd_cnt); end
      end
    end
    model_q.delete();
  endtask

  task automatic test_full();
    model_q.delete();
    for (int j = 0; j < DEPTH; j++) push_cmd(16'($urandom));
    @(negedge clk);
    n_checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL full_set: full %0h empty %0h want 1 0", bus.full, bus.empty); end
    push_cmd(16'hFFFF);
    @(negedge clk);
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %0h want 1", bus.full); end
    drive_seq(-1, 8'h00, 600);
    n_checks++; if (got_cmds.size() != DEPTH) begin n_fail++; $display("FAIL full_nsnd: got %0d want %0d", got_cmds.size(), DEPTH); end
    for (int j = 0; j < got_cmds.size() && j < model_q.size(); j++) begin
      n_checks++; if (got_cmds[j] !== model_q[j]) begin n_fail++; $display("FAIL full_cmd[%0d]: got %0h want %0h", j, got_cmds[j], model_q[j]); end
    end
    n_checks++; if (bus.cmd_cnt !== 5'(DEPTH) || bus.full !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_end: cnt %0d full %0h empty %0h want %0d 0 1", bus.cmd_cnt, bus.full, bus.empty, DEPTH); end
    model_q.delete();
  endtask

  task automatic test_abort();
    int d0;
    logic hit;
    model_q.delete();
    push_cmd(16'hAB01);
    push_cmd(16'hAB02);
    d0 = done_total;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 10 && !hit; t++) begin @(negedge clk); hit = bus.snd_cmd; end
    @(posedge clk); #1 bus.cmd_snt = 1'b1;
    @(posedge clk); #1 bus.cmd_snt = 1'b0; bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0; bus.resp_rdy = 1'b1; bus.resp = 8'hA5;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.resp_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b1 || bus.err_code !== 2'b11) begin n_fail++; $display("FAIL abort_code: got %0h/%0h want 1/3", bus.err, bus.err_code); end
    n_checks++; if (bus.busy !== 1'b0 || bus.cmd_cnt !== 5'd0) begin n_fail++; $display("FAIL abort_late_resp: busy %0h cnt %0d want 0 0", bus.busy, bus.cmd_cnt); end
    n_checks++; if (bus.empty !== 1'b1 || done_total != d0) begin n_fail++; $display("FAIL abort_flush: empty %0h done %0d want 1 0", bus.empty, done_total - d0); end
    model_q.delete();
    push_cmd(16'hBEEF);
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.empty !== 1'b0 || bus.busy !== 1'b0 || bus.err_code !== 2'b11) begin n_fail++; $display("FAIL abort_idle: empty %0h busy %0h code %0h want 0 0 3", bus.empty, bus.busy, bus.err_code); end
    drive_seq(-1, 8'h00, 200);
    n_checks++; if (got_cmds.size() != 1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL abort_recover: nsnd %0d err %0h want 1 0", got_cmds.size(), bus.err); end
    model_q.delete();
  endtask

  task automatic test_reset_mid();
    int d0;
    logic hit;
    model_q.delete();
    push_cmd(16'hC0DE);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 10 && !hit; t++) begin @(negedge clk); hit = bus.snd_cmd; end
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    n_checks++; if (bus.busy !== 1'b0 || bus.snd_cmd !== 1'b0 || bus.cmd !== 16'h0000) begin n_fail++; $display("FAIL rstmid_fsm: busy %0h snd %0h cmd %0h want 0 0 0", bus.busy, bus.snd_cmd, bus.cmd); end
    n_checks++; if (bus.empty !== 1'b1 || bus.err !== 1'b0 || bus.err_code !== 2'b00 || bus.cmd_cnt !== 5'd0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_regs: empty %0h err %0h code %0h cnt %0d done %0h want 1 0 0 0 0", bus.empty, bus.err, bus.err_code, bus.cmd_cnt, bus.done); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_q.delete();
    d0 = done_total;
    repeat (3) @(negedge clk);
    n_checks++; if (done_total != d0) begin n_fail++; $display("FAIL rstmid_nodone: got %0d pulses want 0", done_total - d0); end
    drive_seq(-1, 8'h00, 50);
    n_checks++; if (got_cmds.size() != 0 || done_total - d0 != 1) begin n_fail++; $display("FAIL rstmid_empty_start: nsnd %0d done %0d want 0 1", got_cmds.size(), done_total - d0); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; done_total = 0;
    test_reset();
    test_basic();
    test_random_ok();
    test_bad_resp();
    test_timeout();
    test_full();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
